// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types, defaults and index-width helper for mat_vec_mac_seq
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_VEC = 2'd1,
    MAC      = 2'd2,
    HOLD     = 2'd3
  } mvm_state_t;

  localparam int DEF_ROWS   = 3;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 32;

  // Counter width for n entries; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_acc_add.sv
// rtl/mvm_acc_add.sv - ACC_W adder, wrapping or clamping under MVM_SATURATE_EN
module mvm_acc_add #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

`ifdef MVM_SATURATE_EN
  logic [ACC_W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[ACC_W];
  assign sum  = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mat_vec_mac_seq.sv
// rtl/mat_vec_mac_seq.sv - sequential matrix-vector MAC engine; MVM_SATURATE_EN selects clamping arithmetic
module mat_vec_mac_seq
  import mvm_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [DATA_W-1:0]         vec_data,
  input  logic                      mat_valid,
  output logic                      mat_ready,
  input  logic [DATA_W-1:0]         mat_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic [idx_w(ROWS)-1:0]    res_row,
  output logic                      res_last,
  output logic [ACC_W-1:0]          total_data,
  output logic                      sat
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  mvm_state_t        state;
  logic [DATA_W-1:0] vec_mem [COLS];
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ACC_W-1:0]  acc;

  logic [DATA_W-1:0] vec_sel;
  logic [ACC_W-1:0]  prod_acc;
  logic              prod_ovf;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_ovf;
  logic [ACC_W-1:0]  tot_sum;
  logic              tot_ovf;

  assign vec_sel = vec_mem[col];

`ifdef MVM_SATURATE_EN
  localparam int PW = 2 * DATA_W;
  logic [PW-1:0] prod_full;

  assign prod_full = PW'(mat_data) * PW'(vec_sel);

  if (ACC_W >= PW) begin : g_prod_fit
    assign prod_acc = ACC_W'(prod_full);
    assign prod_ovf = 1'b0;
  end else begin : g_prod_clamp
    assign prod_ovf = |prod_full[PW-1:ACC_W];
    assign prod_acc = prod_ovf ? {ACC_W{1'b1}} : prod_full[ACC_W-1:0];
  end
`else
  // Low ACC_W bits of the product only depend on the low ACC_W bits of each operand.
  assign prod_acc = ACC_W'(mat_data) * ACC_W'(vec_sel);
  assign prod_ovf = 1'b0;
`endif

  mvm_acc_add #(.ACC_W(ACC_W)) u_acc_add (
    .a   (acc),
    .b   (prod_acc),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  // Total chains off the in-flight acc sum so the row result and total land together.
  mvm_acc_add #(.ACC_W(ACC_W)) u_tot_add (
    .a   (total_data),
    .b   (acc_sum),
    .sum (tot_sum),
    .ovf (tot_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < COLS; i++) vec_mem[i] <= '0;
      col        <= '0;
      row        <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_ready  <= 1'b0;
      mat_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_row    <= '0;
      res_last   <= 1'b0;
      total_data <= '0;
      sat        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD_VEC;
            col        <= '0;
            row        <= '0;
            acc        <= '0;
            total_data <= '0;
            sat        <= 1'b0;
            busy       <= 1'b1;
            vec_ready  <= 1'b1;
          end
        end
        LOAD_VEC: begin
          if (vec_valid && vec_ready) begin
            vec_mem[col] <= vec_data;
            if (col == COL_LAST) begin
              col       <= '0;
              state     <= MAC;
              vec_ready <= 1'b0;
              mat_ready <= 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        MAC: begin
          if (mat_valid && mat_ready) begin
            acc <= acc_sum;
            sat <= sat | prod_ovf | acc_ovf;
            if (col == COL_LAST) begin
              col        <= '0;
              res_data   <= acc_sum;
              total_data <= tot_sum;
              sat        <= sat | prod_ovf | acc_ovf | tot_ovf;
              res_valid  <= 1'b1;
              res_row    <= row;
              res_last   <= (row == ROW_LAST);
              mat_ready  <= 1'b0;
              state      <= HOLD;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (res_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              row       <= row + 1'b1;
              acc       <= '0;
              col       <= '0;
              mat_ready <= 1'b1;
              state     <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
